// File: rtl/pl3_mem_hs_pkg.sv
// Shared types for the stage-3 memory handshake block and its lane aligner.
package pl3_mem_hs_pkg;

  typedef logic [31:0] data_val;
  typedef logic [4:0]  reg_addr;

  // Access size/sign; encodings 5..7 are undefined.
  typedef enum logic [2:0] {
    L_S_BYTE   = 3'd0,
    L_S_HALF   = 3'd1,
    L_S_WORD   = 3'd2,
    L_S_BYTE_U = 3'd3,
    L_S_HALF_U = 3'd4
  } l_s_sel;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state;

  // Offset with the bits that must be zero for this access size cleared.
  function automatic logic [1:0] aligned_off(l_s_sel sel, logic [1:0] off);
    case (sel)
      L_S_HALF, L_S_HALF_U: return {off[1], 1'b0};
      L_S_WORD:             return 2'b00;
      default:              return off;
    endcase
  endfunction

  function automatic logic is_misaligned(l_s_sel sel, logic [1:0] off);
    return aligned_off(sel, off) != off;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/data and load extraction/extension.
module mem_lane_align
  import pl3_mem_hs_pkg::*;
(
  input  logic [1:0] off,
  input  l_s_sel     sel,
  input  data_val    wr_val,
  input  data_val    rd_word,
  output logic [3:0] be,
  output data_val    wdata,
  output data_val    rd_val
);

  logic [4:0] sh;
  data_val    rd_shift;

  assign sh       = {off, 3'b000};
  assign wdata    = wr_val << sh;
  assign rd_shift = rd_word >> sh;

  // Size-dependent enables and load extension; undefined sizes give zero.
  always_comb begin
    be     = 4'h0;
    rd_val = '0;
    case (sel)
      L_S_BYTE: begin
        be     = 4'b0001 << off;
        rd_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      L_S_BYTE_U: begin
        be     = 4'b0001 << off;
        rd_val = {24'h0, rd_shift[7:0]};
      end
      L_S_HALF: begin
        be     = 4'b0011 << off;
        rd_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      L_S_HALF_U: begin
        be     = 4'b0011 << off;
        rd_val = {16'h0, rd_shift[15:0]};
      end
      L_S_WORD: begin
        be     = 4'hF;
        rd_val = rd_shift;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pl3_mem_hs.sv
// Pipeline memory stage with a request/response memory handshake.
module pl3_mem_hs
  import pl3_mem_hs_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned TIMEOUT_CYC   = 255,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  data_val           i_alu_out_val,
  input  logic              i_mem_wr_en,
  input  logic              i_mem_rd_en,
  input  data_val           i_mem_wr_val,
  input  l_s_sel            i_l_s_sel_val,
  input  reg_addr           i_ff_addr,
  output logic              o_stall,
  output logic              o_valid,
  output data_val           o_mem_rd_val,
  output reg_addr           o_ff_addr,
  output data_val           o_ff_val,
  output logic              o_misaligned,
  output logic              o_bus_err,
  output logic              o_req,
  output logic              o_req_we,
  output logic [ADDR_W-1:0] o_req_addr,
  output logic [3:0]        o_req_be,
  output data_val           o_req_wdata,
  input  logic              i_req_ready,
  input  logic              i_rsp_valid,
  input  data_val           i_rsp_rdata
);

  mem_state          state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  l_s_sel            sel_q;
  data_val           wr_val_q;
  reg_addr           ff_q;
  logic              we_q;
  logic              latch_en;

  logic    valid_q, valid_d, mis_q, mis_d, berr_q, berr_d;
  data_val val_q, val_d;
  reg_addr ffo_q, ffo_d;

  logic       is_mem, timeout;
  logic [3:0] al_be;
  data_val    al_wdata, al_rd_val;

  assign is_mem  = i_mem_rd_en | i_mem_wr_en;
  // Timeout fires in the cycle that spends the last allowed REQ/WAIT cycle.
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_CYC - 1);

  mem_lane_align u_align (
    .off     (off_q),
    .sel     (sel_q),
    .wr_val  (wr_val_q),
    .rd_word (i_rsp_rdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .rd_val  (al_rd_val)
  );

  // Next state, timeout count and the registered result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    latch_en = 1'b0;
    valid_d  = 1'b0;
    val_d    = '0;
    ffo_d    = '0;
    mis_d    = 1'b0;
    berr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!is_mem) begin
            valid_d = 1'b1;
            val_d   = i_alu_out_val;
            ffo_d   = i_ff_addr;
          end else if (MISALIGN_TRAP && is_misaligned(i_l_s_sel_val, i_alu_out_val[1:0])) begin
            valid_d = 1'b1;
            mis_d   = 1'b1;
          end else begin
            latch_en = 1'b1;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 32'd1;
        if (i_req_ready) begin
          if (we_q) begin
            state_d = IDLE;
            valid_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout) begin
          state_d = IDLE;
          valid_d = 1'b1;
          berr_d  = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (i_rsp_valid) begin
          state_d = IDLE;
          valid_d = 1'b1;
          val_d   = al_rd_val;
          ffo_d   = ff_q;
        end else if (timeout) begin
          state_d = IDLE;
          valid_d = 1'b1;
          berr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      val_q   <= '0;
      ffo_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      val_q   <= val_d;
      ffo_q   <= ffo_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  // Capture the accepted memory op; a write wins over a simultaneous read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q   <= '0;
      off_q    <= '0;
      sel_q    <= L_S_BYTE;
      wr_val_q <= '0;
      ff_q     <= '0;
      we_q     <= 1'b0;
    end else if (latch_en) begin
      addr_q   <= i_alu_out_val[ADDR_W-1:0];
      off_q    <= aligned_off(i_l_s_sel_val, i_alu_out_val[1:0]);
      sel_q    <= i_l_s_sel_val;
      wr_val_q <= i_mem_wr_val;
      ff_q     <= i_ff_addr;
      we_q     <= i_mem_wr_en;
    end
  end

  assign o_stall      = (state_q != IDLE);
  assign o_req        = (state_q == REQ);
  assign o_req_we     = o_req & we_q;
  assign o_req_addr   = o_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign o_req_be     = o_req ? al_be : 4'h0;
  assign o_req_wdata  = o_req ? al_wdata : '0;
  assign o_valid      = valid_q;
  assign o_mem_rd_val = val_q;
  assign o_ff_val     = val_q;
  assign o_ff_addr    = ffo_q;
  assign o_misaligned = mis_q;
  assign o_bus_err    = berr_q;

endmodule

// File: doc/pl3_mem_hs.md
Name: pl3_mem_hs

Overview:
- Parametrised successor to the fixed-latency pipeline memory stage (stage 3).
- Talks to a variable-latency memory through a request/response handshake and stalls the pipeline while an access is outstanding.
- Aligns store data and generates byte enables from the address offset; aligns and sign/zero-extends load data.
- Detects misaligned accesses and bus timeouts, and presents the writeback/forwarding result registered, with a valid flag.

Parameters:
- ADDR_W, 32: address bits driven on o_req_addr; upper ALU bits are dropped.
- TIMEOUT_CYC, 255: cycles allowed in REQ+WAIT before a bus error. 0 disables the timeout.
- MISALIGN_TRAP, 1: 1 = a misaligned access raises an error and makes no memory access. 0 = low offset bits are forced to zero and the access proceeds.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_valid  in  1  instruction present in stage
- i_alu_out_val  in  data_val  address (mem op) or result (non-mem op)
- i_mem_wr_en  in  1  store
- i_mem_rd_en  in  1  load
- i_mem_wr_val  in  data_val  store data
- i_l_s_sel_val  in  l_s_sel  access size/sign
- i_ff_addr  in  reg_addr  destination register
- o_stall  out  1  upstream must hold its outputs
- o_valid  out  1  result valid this cycle
- o_mem_rd_val  out  data_val  writeback value
- o_ff_addr  out  reg_addr  destination register of the result
- o_ff_val  out  data_val  forwarding value, equal to o_mem_rd_val
- o_misaligned  out  1  misaligned access (1-cycle, with o_valid)
- o_bus_err  out  1  timeout (1-cycle, with o_valid)
- o_req  out  1  memory request
- o_req_we  out  1  request is a write
- o_req_addr  out  ADDR_W  word-aligned request address
- o_req_be  out  4  byte enables
- o_req_wdata  out  data_val  lane-aligned store data
- i_req_ready  in  1  memory accepts the request
- i_rsp_valid  in  1  read data valid
- i_rsp_rdata  in  data_val  full read word

Behaviour:
- Clocking and reset:
  - One clock: i_clk.
  - Reset i_rst is synchronous and active-high.
  - On reset: state = IDLE, timeout counter = 0, and all outputs = 0 (including o_req and o_stall).
- FSM states: IDLE, REQ, WAIT.
- Stall rule:
  - o_stall = (state != IDLE).
  - Upstream holds its inputs while o_stall = 1. The held instruction is consumed in the first cycle o_stall = 0.
- IDLE, non-mem op (i_valid=1, rd=wr=0):
  - Next cycle: o_valid=1, o_mem_rd_val=i_alu_out_val, o_ff_addr=i_ff_addr.
  - Latency 1.
- IDLE, mem op: latch address, offset, l_s_sel, write data, ff_addr and direction, then go to REQ.
  - If both rd and wr are set, the write wins and the read is suppressed.
- Alignment rule:
  - Half requires addr[0]=0. Word requires addr[1:0]=0.
  - Misaligned with MISALIGN_TRAP=1: stay in IDLE and issue no request. Next cycle: o_valid=1, o_misaligned=1, o_mem_rd_val=0.
- REQ:
  - o_req=1; o_req_addr={addr[ADDR_W-1:2],2'b00}.
  - o_req_be: 1<<off for byte, 3<<off for half, 4'hF for word.
  - o_req_wdata = wr_val shifted left by off*8.
  - Request fields stay stable until i_req_ready=1.
  - On ready:
    - Write: go to IDLE. Next cycle o_valid=1 with ff_addr=0 and value=0.
    - Read: go to WAIT.
- WAIT:
  - On i_rsp_valid: shift rdata right by off*8, then extend (BYTE/HALF signed, BYTE_U/HALF_U zero, WORD passthrough).
  - Register the result; o_valid=1 next cycle; go to IDLE.
  - An undefined l_s_sel gives value 0.
- Timeout:
  - The counter increments each cycle in REQ or WAIT and clears in IDLE.
  - When the counter reaches TIMEOUT_CYC: go to IDLE and drop o_req. Next cycle: o_valid=1, o_bus_err=1, value 0.
- Boundary cases:
  - i_req_ready and timeout in the same cycle: ready wins.
  - i_rsp_valid while in IDLE or REQ: ignored (no o_valid).
  - Reset mid-operation: o_req drops next cycle; a late response is ignored.
  - o_valid, o_misaligned and o_bus_err are single-cycle pulses. At most one instruction is in flight.

Decomposition:
- Shared package: l_s_sel (L_S_BYTE, L_S_HALF, L_S_WORD, L_S_BYTE_U, L_S_HALF_U), data_val, reg_addr, and the new mem_state enum (IDLE, REQ, WAIT).
- One sub-module, mem_lane_align (combinational): given offset and l_s_sel, it produces be, wdata and the extended read value. It is reused by future cache blocks.

Test Plan:
- Non-mem op, alu=32'h1234_5678, ff_addr=5 -> next cycle o_valid=1, o_mem_rd_val=32'h1234_5678, o_ff_addr=5, no o_req.
- LB at addr 0x103, i_req_ready held 0 for 3 cycles, rsp rdata=32'h80AA_BBCC -> o_req_addr=0x100, o_stall high until response; o_mem_rd_val=32'hFFFF_FF80. Repeat with LBU -> 32'h0000_0080.
- SH at addr 0x202, wr_val=32'h0000_BEEF, immediate ready -> o_req_we=1, be=4'b1100, wdata=32'hBEEF_0000, then o_valid=1 with ff_addr=0.
- LW at addr 0x301 with MISALIGN_TRAP=1 -> no o_req; next cycle o_valid=1, o_misaligned=1, value 0.
- LW with TIMEOUT_CYC=4 and no response -> o_bus_err=1 after 4 cycles, state IDLE; a late i_rsp_valid produces no o_valid.
- Assert i_rst during WAIT -> next cycle o_req=0 and o_stall=0; the following instruction is processed normally.
